// File: rtl/cache_pkg.sv
// Shared types and helpers for the 2-way set-associative cache controller.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        REFILL,
        RESP
    } state_t;

    localparam logic WAY0 = 1'b0;
    localparam logic WAY1 = 1'b1;

    // Address helpers work on a wide container; callers cast to their field width.
    function automatic logic [63:0] idx_of(input logic [63:0] adr, input int unsigned index_w);
        return adr & ((64'd1 << index_w) - 64'd1);
    endfunction

    function automatic logic [63:0] tag_of(input logic [63:0] adr, input int unsigned index_w);
        return adr >> index_w;
    endfunction

endpackage

// File: rtl/cache_way_array.sv
// One cache way: per-set valid/dirty/tag/data, asynchronous read port, one write port.
module cache_way_array
    import cache_pkg::*;
#(
    parameter int unsigned SETS   = 16,
    parameter int unsigned TAG_W  = 12,
    parameter int unsigned DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [$clog2(SETS)-1:0] rd_idx_i,
    output logic                    rd_valid_o,
    output logic                    rd_dirty_o,
    output logic [TAG_W-1:0]        rd_tag_o,
    output logic [DATA_W-1:0]       rd_data_o,
    input  logic                    wr_en_i,
    input  logic [$clog2(SETS)-1:0] wr_idx_i,
    input  logic                    wr_dirty_i,
    input  logic [TAG_W-1:0]        wr_tag_i,
    input  logic [DATA_W-1:0]       wr_data_i
);

    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [DATA_W-1:0] data_q [SETS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
            dirty_q[wr_idx_i] <= wr_dirty_i;
        end
    end

    // Tag/data payload is qualified by valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_dirty_o = dirty_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/cache_ctrl_2way.sv
// 2-way set-associative write-back/write-allocate cache controller with true LRU.
// Define CACHE_STATS_EN to add saturating hit/miss counter outputs.
module cache_ctrl_2way
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SETS   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_cpu_i,
    input  logic              we_cpu_i,
    input  logic [ADDR_W-1:0] adr_cpu_i,
    input  logic [DATA_W-1:0] dat_cpu_i,
    output logic [DATA_W-1:0] dat_cpu_o,
    output logic              ack_cpu_o,
    output logic              err_cpu_o,
    output logic              cyc_m2s,
    output logic              we_m2s,
    output logic [ADDR_W-1:0] adr_m2s,
    output logic [DATA_W-1:0] dat_m2s,
    input  logic [DATA_W-1:0] dat_mem_i,
    input  logic              ack_mem_i,
    input  logic              err_mem_i
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int unsigned INDEX_W = $clog2(SETS);
    localparam int unsigned TAG_W   = ADDR_W - INDEX_W;

    state_t            state_q;
    logic [ADDR_W-1:0] adr_q;
    logic [DATA_W-1:0] dat_q;
    logic              we_q;
    logic              victim_q;
    logic [SETS-1:0]   lru_q;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [1:0]         rd_valid, rd_dirty;
    logic [TAG_W-1:0]   rd_tag  [2];
    logic [DATA_W-1:0]  rd_data [2];
    logic [1:0]         wr_en;
    logic               wr_dirty;
    logic [TAG_W-1:0]   wr_tag;
    logic [DATA_W-1:0]  wr_data;
    logic               hit0, hit1, hit, hit_way, miss_way, victim_dirty;

    assign idx = INDEX_W'(idx_of(64'(adr_q), INDEX_W));
    assign tag = TAG_W'(tag_of(64'(adr_q), INDEX_W));

    cache_way_array #(.SETS(SETS), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_way0 (
        .clk(clk), .rst(rst), .rd_idx_i(idx),
        .rd_valid_o(rd_valid[0]), .rd_dirty_o(rd_dirty[0]),
        .rd_tag_o(rd_tag[0]), .rd_data_o(rd_data[0]),
        .wr_en_i(wr_en[0]), .wr_idx_i(idx), .wr_dirty_i(wr_dirty),
        .wr_tag_i(wr_tag), .wr_data_i(wr_data)
    );

    cache_way_array #(.SETS(SETS), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_way1 (
        .clk(clk), .rst(rst), .rd_idx_i(idx),
        .rd_valid_o(rd_valid[1]), .rd_dirty_o(rd_dirty[1]),
        .rd_tag_o(rd_tag[1]), .rd_data_o(rd_data[1]),
        .wr_en_i(wr_en[1]), .wr_idx_i(idx), .wr_dirty_i(wr_dirty),
        .wr_tag_i(wr_tag), .wr_data_i(wr_data)
    );

    assign hit0         = rd_valid[0] && (rd_tag[0] == tag);
    assign hit1         = rd_valid[1] && (rd_tag[1] == tag);
    assign hit          = hit0 | hit1;
    assign hit_way      = hit1 ? WAY1 : WAY0;
    assign miss_way     = !rd_valid[0] ? WAY0 : (!rd_valid[1] ? WAY1 : lru_q[idx]);
    assign victim_dirty = rd_valid[miss_way] & rd_dirty[miss_way];

    // Write-back ack on a read rewrites the victim with dirty cleared; on a write it installs the new line.
    always_comb begin
        wr_en    = '0;
        wr_dirty = 1'b1;
        wr_tag   = tag;
        wr_data  = dat_q;
        case (state_q)
            LOOKUP: begin
                if (hit) begin
                    if (we_q) wr_en[hit_way] = 1'b1;
                end else if (we_q && !victim_dirty) begin
                    wr_en[miss_way] = 1'b1;
                end
            end
            WRITEBACK: begin
                if (!err_mem_i && ack_mem_i) begin
                    wr_en[victim_q] = 1'b1;
                    if (!we_q) begin
                        wr_dirty = 1'b0;
                        wr_tag   = rd_tag[victim_q];
                        wr_data  = rd_data[victim_q];
                    end
                end
            end
            REFILL: begin
                if (!err_mem_i && ack_mem_i) begin
                    wr_en[victim_q] = 1'b1;
                    wr_dirty        = 1'b0;
                    wr_data         = dat_mem_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            adr_q     <= '0;
            dat_q     <= '0;
            we_q      <= 1'b0;
            victim_q  <= WAY0;
            lru_q     <= '0;
            dat_cpu_o <= '0;
            ack_cpu_o <= 1'b0;
            err_cpu_o <= 1'b0;
            cyc_m2s   <= 1'b0;
            we_m2s    <= 1'b0;
            adr_m2s   <= '0;
            dat_m2s   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_cpu_i) begin
                        adr_q   <= adr_cpu_i;
                        dat_q   <= dat_cpu_i;
                        we_q    <= we_cpu_i;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        if (!we_q) dat_cpu_o <= rd_data[hit_way];
                        lru_q[idx] <= ~hit_way;
                        ack_cpu_o  <= 1'b1;
                        state_q    <= RESP;
                    end else begin
                        victim_q <= miss_way;
                        if (victim_dirty) begin
                            cyc_m2s <= 1'b1;
                            we_m2s  <= 1'b1;
                            adr_m2s <= {rd_tag[miss_way], idx};
                            dat_m2s <= rd_data[miss_way];
                            state_q <= WRITEBACK;
                        end else if (!we_q) begin
                            cyc_m2s <= 1'b1;
                            we_m2s  <= 1'b0;
                            adr_m2s <= adr_q;
                            state_q <= REFILL;
                        end else begin
                            lru_q[idx] <= ~miss_way;
                            ack_cpu_o  <= 1'b1;
                            state_q    <= RESP;
                        end
                    end
                end
                WRITEBACK: begin
                    if (err_mem_i) begin
                        cyc_m2s   <= 1'b0;
                        we_m2s    <= 1'b0;
                        err_cpu_o <= 1'b1;
                        state_q   <= RESP;
                    end else if (ack_mem_i) begin
                        we_m2s <= 1'b0;
                        if (we_q) begin
                            cyc_m2s    <= 1'b0;
                            lru_q[idx] <= ~victim_q;
                            ack_cpu_o  <= 1'b1;
                            state_q    <= RESP;
                        end else begin
                            adr_m2s <= adr_q;
                            state_q <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (err_mem_i) begin
                        cyc_m2s   <= 1'b0;
                        err_cpu_o <= 1'b1;
                        state_q   <= RESP;
                    end else if (ack_mem_i) begin
                        cyc_m2s    <= 1'b0;
                        lru_q[idx] <= ~victim_q;
                        dat_cpu_o  <= dat_mem_i;
                        ack_cpu_o  <= 1'b1;
                        state_q    <= RESP;
                    end
                end
                RESP: begin
                    ack_cpu_o <= 1'b0;
                    err_cpu_o <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (state_q == LOOKUP) begin
            if (hit && hit_cnt_o != '1)   hit_cnt_o  <= hit_cnt_o + 32'd1;
            if (!hit && miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Directed self-checking bench for cache_ctrl_2way with a latency-programmable memory responder.
// Build with CACHE_STATS_EN defined to also exercise the hit/miss counters.
module tb_cache_ctrl_2way;

    logic        clk;
    logic        rst;
    logic        req_cpu, we_cpu;
    logic [15:0] adr_cpu;
    logic [31:0] dat_cpu_i, dat_cpu_o;
    logic        ack_cpu_o, err_cpu_o;
    logic        cyc_m2s, we_m2s;
    logic [15:0] adr_m2s;
    logic [31:0] dat_m2s;
    logic [31:0] dat_mem = '0;
    logic        ack_mem = 1'b0;
    logic        err_mem = 1'b0;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int          total = 0;
    int          bad   = 0;

    int          mem_lat;
    logic        mem_err_mode;
    logic [31:0] mem_rdata;
    int          mcnt       = 0;
    int          txn_cnt    = 0;
    int          cyc_cycles = 0;
    logic [15:0] log_adr [64];
    logic        log_we  [64];
    logic [31:0] log_dat [64];

    cache_ctrl_2way #(.ADDR_W(16), .DATA_W(32), .SETS(16)) dut (
        .clk(clk), .rst(rst),
        .req_cpu_i(req_cpu), .we_cpu_i(we_cpu), .adr_cpu_i(adr_cpu), .dat_cpu_i(dat_cpu_i),
        .dat_cpu_o(dat_cpu_o), .ack_cpu_o(ack_cpu_o), .err_cpu_o(err_cpu_o),
        .cyc_m2s(cyc_m2s), .we_m2s(we_m2s), .adr_m2s(adr_m2s), .dat_m2s(dat_m2s),
        .dat_mem_i(dat_mem), .ack_mem_i(ack_mem), .err_mem_i(err_mem)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responds mem_lat falling edges into each cycle and logs every response.
    always @(negedge clk) begin
        if (cyc_m2s) cyc_cycles++;
        if (!cyc_m2s || ack_mem || err_mem) begin
            ack_mem = 1'b0;
            err_mem = 1'b0;
            mcnt    = 0;
        end else begin
            mcnt++;
            if (mcnt >= mem_lat) begin
                if (mem_err_mode) err_mem = 1'b1;
                else begin
                    ack_mem = 1'b1;
                    dat_mem = mem_rdata;
                end
                log_adr[txn_cnt % 64] = adr_m2s;
                log_we[txn_cnt % 64]  = we_m2s;
                log_dat[txn_cnt % 64] = dat_m2s;
                txn_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_cpu = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cpu_op(input logic we, input logic [15:0] adr, input logic [31:0] dat,
                          output int lat, output logic [31:0] rdata,
                          output logic got_ack, output logic got_err);
        @(negedge clk);
        req_cpu = 1'b1; we_cpu = we; adr_cpu = adr; dat_cpu_i = dat;
        lat = 0; got_ack = 1'b0; got_err = 1'b0; rdata = '0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (ack_cpu_o || err_cpu_o) begin
                got_ack = ack_cpu_o;
                got_err = err_cpu_o;
                rdata   = dat_cpu_o;
                break;
            end
        end
        req_cpu = 1'b0;
        total++;
        if (!got_ack && !got_err) begin
            bad++;
            $display("FAIL cpu_timeout: adr=%h no ack/err within %0d cycles", adr, lat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({cyc_m2s, we_m2s, ack_cpu_o, err_cpu_o} !== 4'b0000 || dat_cpu_o !== 32'h0 ||
            adr_m2s !== 16'h0 || dat_m2s !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: got cyc=%b we=%b ack=%b err=%b dat=%h adr=%h mdat=%h want all 0",
                     cyc_m2s, we_m2s, ack_cpu_o, err_cpu_o, dat_cpu_o, adr_m2s, dat_m2s);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (cyc_m2s !== 1'b0 || ack_cpu_o !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle: got cyc=%b ack=%b want 0 0", cyc_m2s, ack_cpu_o);
        end
    endtask

    task automatic test_read_refill();
        int lat; logic [31:0] rd; logic ga, ge; int base, cbase;
        do_reset();
        mem_lat = 3; mem_err_mode = 1'b0; mem_rdata = 32'hDEADBEEF;
        base = txn_cnt;
        cpu_op(1'b0, 16'h0010, 32'h0, lat, rd, ga, ge);
        total++;
        if (ga !== 1'b1 || ge !== 1'b0 || rd !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL miss_read_data: got ack=%b err=%b dat=%h want 1 0 deadbeef", ga, ge, rd);
        end
        total++;
        if (lat != 5) begin
            bad++;
            $display("FAIL miss_read_latency: got %0d want 5", lat);
        end
        total++;
        if (txn_cnt - base != 1 || log_adr[base % 64] !== 16'h0010 || log_we[base % 64] !== 1'b0) begin
            bad++;
            $display("FAIL refill_cycle: got n=%0d adr=%h we=%b want 1 0010 0",
                     txn_cnt - base, log_adr[base % 64], log_we[base % 64]);
        end
        @(negedge clk);
        total++;
        if (ack_cpu_o !== 1'b0) begin
            bad++;
            $display("FAIL ack_single_pulse: got %b want 0", ack_cpu_o);
        end
        cbase = cyc_cycles;
        cpu_op(1'b0, 16'h0010, 32'h0, lat, rd, ga, ge);
        total++;
        if (ga !== 1'b1 || rd !== 32'hDEADBEEF || lat != 2) begin
            bad++;
            $display("FAIL hit_read: got ack=%b dat=%h lat=%0d want 1 deadbeef 2", ga, rd, lat);
        end
        total++;
        if (cyc_cycles != cbase) begin
            bad++;
            $display("FAIL hit_no_mem: got %0d cyc cycles want 0", cyc_cycles - cbase);
        end
    endtask

`ifdef CACHE_STATS_EN
    task automatic test_stats();
        total++;
        if (hit_cnt !== 32'd1 || miss_cnt !== 32'd1) begin
            bad++;
            $display("FAIL stats_counts: got hit=%0d miss=%0d want 1 1", hit_cnt, miss_cnt);
        end
    endtask
`endif

    task automatic test_write_alloc();
        int lat; logic [31:0] rd; logic ga, ge; int base;
        base = txn_cnt;
        cpu_op(1'b1, 16'h0000, 32'hAAAA0001, lat, rd, ga, ge);
        total++;
        if (ga !== 1'b1 || lat != 2 || txn_cnt != base) begin
            bad++;
            $display("FAIL write_miss_alloc: got ack=%b lat=%0d txns=%0d want 1 2 0", ga, lat, txn_cnt - base);
        end
        cpu_op(1'b0, 16'h0000, 32'h0, lat, rd, ga, ge);
        total++;
        if (ga !== 1'b1 || rd !== 32'hAAAA0001 || lat != 2 || txn_cnt != base) begin
            bad++;
            $display("FAIL read_after_write: got ack=%b dat=%h lat=%0d txns=%0d want 1 aaaa0001 2 0",
                     ga, rd, lat, txn_cnt - base);
        end
    endtask

    task automatic test_lru_writeback();
        int lat; logic [31:0] rd; logic ga, ge; int base;
        do_reset();
        mem_lat = 3;
        cpu_op(1'b1, 16'h0000, 32'h0000000A, lat, rd, ga, ge);
        mem_rdata = 32'h00001010;
        cpu_op(1'b0, 16'h0010, 32'h0, lat, rd, ga, ge);
        cpu_op(1'b0, 16'h0000, 32'h0, lat, rd, ga, ge);
        total++;
        if (rd !== 32'h0000000A || lat != 2) begin
            bad++;
            $display("FAIL set0_hit_way0: got dat=%h lat=%0d want 0000000a 2", rd, lat);
        end
        mem_rdata = 32'h00002020;
        base = txn_cnt;
        cpu_op(1'b0, 16'h0020, 32'h0, lat, rd, ga, ge);
        total++;
        if (txn_cnt - base != 1 || log_we[base % 64] !== 1'b0 || log_adr[base % 64] !== 16'h0020 ||
            rd !== 32'h00002020 || lat != 5) begin
            bad++;
            $display("FAIL clean_victim_refill: got n=%0d we=%b adr=%h dat=%h lat=%0d want 1 0 0020 00002020 5",
                     txn_cnt - base, log_we[base % 64], log_adr[base % 64], rd, lat);
        end
        mem_rdata = 32'h00003030;
        base = txn_cnt;
        cpu_op(1'b0, 16'h0030, 32'h0, lat, rd, ga, ge);
        total++;
        if (txn_cnt - base != 2) begin
            bad++;
            $display("FAIL dirty_miss_txns: got %0d want 2", txn_cnt - base);
        end
        total++;
        if (log_we[base % 64] !== 1'b1 || log_adr[base % 64] !== 16'h0000 || log_dat[base % 64] !== 32'h0000000A) begin
            bad++;
            $display("FAIL writeback_cycle: got we=%b adr=%h dat=%h want 1 0000 0000000a",
                     log_we[base % 64], log_adr[base % 64], log_dat[base % 64]);
        end
        total++;
        if (log_we[(base + 1) % 64] !== 1'b0 || log_adr[(base + 1) % 64] !== 16'h0030 ||
            rd !== 32'h00003030 || lat != 9) begin
            bad++;
            $display("FAIL refill_after_wb: got we=%b adr=%h dat=%h lat=%0d want 0 0030 00003030 9",
                     log_we[(base + 1) % 64], log_adr[(base + 1) % 64], rd, lat);
        end
    endtask

    task automatic test_mem_error();
        int lat; logic [31:0] rd; logic ga, ge; int base;
        mem_lat = 3; mem_err_mode = 1'b1;
        cpu_op(1'b0, 16'h0045, 32'h0, lat, rd, ga, ge);
        total++;
        if (ge !== 1'b1 || ga !== 1'b0 || lat != 5) begin
            bad++;
            $display("FAIL refill_error: got err=%b ack=%b lat=%0d want 1 0 5", ge, ga, lat);
        end
        @(negedge clk);
        total++;
        if (err_cpu_o !== 1'b0 || cyc_m2s !== 1'b0) begin
            bad++;
            $display("FAIL err_single_pulse: got err=%b cyc=%b want 0 0", err_cpu_o, cyc_m2s);
        end
        mem_err_mode = 1'b0; mem_rdata = 32'h00004545;
        base = txn_cnt;
        cpu_op(1'b0, 16'h0045, 32'h0, lat, rd, ga, ge);
        total++;
        if (ga !== 1'b1 || txn_cnt - base != 1 || rd !== 32'h00004545 || lat != 5) begin
            bad++;
            $display("FAIL no_alloc_on_err: got ack=%b n=%0d dat=%h lat=%0d want 1 1 00004545 5",
                     ga, txn_cnt - base, rd, lat);
        end
    endtask

    task automatic test_reset_in_writeback();
        int lat; logic [31:0] rd; logic ga, ge; int base; logic seen;
        do_reset();
        mem_lat = 3;
        cpu_op(1'b1, 16'h0000, 32'h00000011, lat, rd, ga, ge);
        cpu_op(1'b1, 16'h0010, 32'h00000022, lat, rd, ga, ge);
        mem_lat = 20;
        @(negedge clk);
        req_cpu = 1'b1; we_cpu = 1'b0; adr_cpu = 16'h0020;
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (cyc_m2s) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen || we_m2s !== 1'b1 || adr_m2s !== 16'h0000 || dat_m2s !== 32'h00000011) begin
            bad++;
            $display("FAIL wb_setup: got seen=%b we=%b adr=%h dat=%h want 1 1 0000 00000011",
                     seen, we_m2s, adr_m2s, dat_m2s);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (cyc_m2s !== 1'b0 || ack_cpu_o !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_drop: got cyc=%b ack=%b want 0 0", cyc_m2s, ack_cpu_o);
        end
        req_cpu = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mem_lat = 3; mem_rdata = 32'h00005A5A;
        base = txn_cnt;
        cpu_op(1'b0, 16'h0000, 32'h0, lat, rd, ga, ge);
        total++;
        if (ga !== 1'b1 || txn_cnt - base != 1 || log_we[base % 64] !== 1'b0 ||
            log_adr[base % 64] !== 16'h0000 || rd !== 32'h00005A5A || lat != 5) begin
            bad++;
            $display("FAIL miss_after_reset: got ack=%b n=%0d we=%b adr=%h dat=%h lat=%0d want 1 1 0 0000 00005a5a 5",
                     ga, txn_cnt - base, log_we[base % 64], log_adr[base % 64], rd, lat);
        end
    endtask

    initial begin
        rst = 1'b1; req_cpu = 1'b0; we_cpu = 1'b0; adr_cpu = '0; dat_cpu_i = '0;
        mem_lat = 3; mem_err_mode = 1'b0; mem_rdata = '0;
        test_reset();
        test_read_refill();
`ifdef CACHE_STATS_EN
        test_stats();
`endif
        test_write_alloc();
        test_lru_writeback();
        test_mem_error();
        test_reset_in_writeback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_ctrl_2way.md
Name: cache_ctrl_2way

Overview:
- Parametrised successor to the single-bit cache controller: a 2-way set-associative, write-back, write-allocate cache controller.
- Contains its own tag/valid/dirty/data storage, true-LRU per set, and a victim write-back path.
- Sits between the CPU request port and the memory bus (cyc/we/adr/dat, ack/err).
- Line = one data word; addressing is word-granular.

Parameters:
ADDR_W, 16, CPU/memory word-address width
DATA_W, 32, data word width
SETS, 16, number of sets; power of 2, >=2; INDEX_W=$clog2(SETS), TAG_W=ADDR_W-INDEX_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_cpu_i  in  1  CPU request; held until ack/err
we_cpu_i  in  1  1=write, 0=read
adr_cpu_i  in  ADDR_W  word address; index=adr[INDEX_W-1:0], tag=upper bits
dat_cpu_i  in  DATA_W  write data
dat_cpu_o  out  DATA_W  read data, valid with ack_cpu_o
ack_cpu_o  out  1  1-cycle completion pulse
err_cpu_o  out  1  1-cycle error pulse
cyc_m2s  out  1  memory cycle active
we_m2s  out  1  memory write
adr_m2s  out  ADDR_W  memory address
dat_m2s  out  DATA_W  memory write data
dat_mem_i  in  DATA_W  memory read data
ack_mem_i  in  1  memory ack
err_mem_i  in  1  memory error

Behaviour:
- Reset (async):
  - state=IDLE; all valid, dirty and LRU bits = 0.
  - All outputs 0; dat_cpu_o=0.
  - An in-flight memory cycle is dropped: cyc_m2s falls immediately, nothing is retried.
- States: IDLE, LOOKUP, WRITEBACK, REFILL, RESP.
- IDLE:
  - On req_cpu_i=1, register adr/dat/we, then go to LOOKUP.
  - CPU inputs are ignored in every other state.
- LOOKUP: compare the registered tag against both ways of the indexed set.
  - Hit, read: dat_cpu_o<=way data.
  - Hit, write: way data<=dat; dirty<=1.
  - Either hit: LRU<=other way; go to RESP.
  - Miss: victim = first invalid way (way0 before way1), else the LRU way.
    - Victim valid and dirty: go to WRITEBACK.
    - Else if read: go to REFILL.
    - Else (write): write line directly (tag, data, valid=1, dirty=1, LRU<=other way); go to RESP. No memory fetch, since line = one word.
- WRITEBACK:
  - Drive cyc=1, we=1, adr={victim tag,index}, dat=victim data.
  - On ack_mem_i: clear victim dirty; for a read go to REFILL (new cyc setup); for a write perform the direct write as in LOOKUP, then go to RESP.
- REFILL:
  - Drive cyc=1, we=0, adr=registered adr.
  - On ack_mem_i: install tag, data=dat_mem_i, valid=1, dirty=0; LRU<=other way; dat_cpu_o<=dat_mem_i; go to RESP.
- Memory outputs are registered and held stable while cyc_m2s=1; cyc_m2s=0 in IDLE, LOOKUP and RESP.
- err_mem_i in WRITEBACK or REFILL:
  - cyc drops, no array update (victim stays dirty), go to RESP with the err flag set.
  - If err_mem_i and ack_mem_i are high together, err wins.
  - ack_mem_i/err_mem_i are ignored while cyc_m2s=0.
- RESP:
  - Exactly one cycle: ack_cpu_o=1 (or err_cpu_o=1; never both); then IDLE.
  - CPU must drop req in the cycle after it sees ack/err.
- Latency:
  - Hit: ack 2 cycles after req first sampled.
  - Clean read miss: 2 cycles + memory wait.
  - Dirty miss: adds one full write-back cycle.

Optional Feature:
- Macro CACHE_STATS_EN.
- Defined: adds outputs hit_cnt_o and miss_cnt_o, 32 bits each.
  - Hit counter increments in LOOKUP on a hit; miss counter increments in LOOKUP on a miss.
  - Counters saturate at all-ones and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cache_pkg holds:
  - state enum (IDLE..RESP);
  - way-select constants WAY0/WAY1;
  - helper functions idx_of(adr) and tag_of(adr).
- One sub-module, cache_way_array (SETS x {valid, dirty, tag, data}, 1 read port + 1 write port), instantiated twice.
- LRU bit vector and FSM stay in the top level.

Test Plan (ADDR_W=16, DATA_W=32, SETS=16):
1. Reset, then read 0x0010; memory acks 0xDEADBEEF after 3 cycles -> one memory cycle with adr 0x0010, we=0; ack_cpu_o with 0xDEADBEEF. Re-read 0x0010 -> ack 2 cycles after req, cyc_m2s stays 0.
2. Write 0x0000=0xAAAA0001 (miss) -> no memory cycle, ack; read 0x0000 -> hit, returns 0xAAAA0001.
3. Fill set 0, check LRU and write-back:
   - Write 0x0000=0xA, read 0x0010, read 0x0000 (hit), then read 0x0020 -> way1 clean victim, single refill, no write-back.
   - Read 0x0030 -> write-back cycle adr 0x0000, dat 0xA, then refill 0x0030.
4. Read miss with err_mem_i during refill -> err_cpu_o pulse, ack_cpu_o=0. Repeat read -> misses again (no allocation).
5. Assert rst while cyc_m2s=1 in WRITEBACK -> cyc_m2s=0 the same cycle. After release, a read of the previously cached address misses.
6. With CACHE_STATS_EN, run scenario 1 -> hit_cnt_o=1, miss_cnt_o=1.
